// File: rtl/stream_combiner.sv
// Packs framed 16*P-bit beats LSB-first into 512-bit MIG write words; word registered 1 cycle after its last beat.
// Backpressure: iready = !ovalid | oready, output word held while ovalid & !oready; sticky err on framing/length faults.
module stream_combiner #(
   parameter int P = 8
) (
   input  logic              ui_clk,
   input  logic              sys_rst,
   input  logic [15:0]       messagesize,
   input  logic              msvalid,
   input  logic [16*P-1:0]   idata,
   input  logic              ivalid,
   input  logic              istart,
   input  logic              ilast,
   output logic              iready,
   output logic [511:0]      odata,
   output logic              ovalid,
   output logic              ostart,
   output logic              olast,
   input  logic              oready,
   output logic [15:0]       wordcount,
   output logic              err
);
   localparam int W     = 16 * P;
   localparam int BEATS = 512 / W;
   localparam int IW    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(BEATS - 1);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_PACK = 1'b1;

   logic [0:0]    r_state;
   logic [IW-1:0] r_idx;
   logic [511:0]  r_asm;
   logic [15:0]   r_expbeats;
   logic [15:0]   r_cnt;
   logic          r_first;

   logic          w_acc;
   logic          w_start;
   logic          w_restart;
   logic          w_drop;
   logic          w_take;
   logic          w_done;
   logic          w_len_err;
   logic [IW-1:0] w_slot;
   logic [511:0]  w_word;
   logic [15:0]   w_exp;
   logic [15:0]   w_cnt_nxt;

   assign iready    = !ovalid | oready;
   assign w_acc     = ivalid & iready;
   assign w_start   = w_acc & istart;
   assign w_restart = w_start & (r_state == S_PACK);
   assign w_drop    = w_acc & !istart & (r_state == S_IDLE);
   assign w_take    = w_start | (w_acc & (r_state == S_PACK));

   // A start beat always lands in slot 0 and ignores any partial word left behind.
   assign w_slot    = w_start ? '0 : r_idx;
   assign w_done    = w_take & ((w_slot == LAST_IDX) | ilast);
   assign w_word    = (w_start ? 512'd0 : r_asm) | (512'(idata) << (W * 32'(w_slot)));

   assign w_exp     = (messagesize / 16'(P)) + {15'd0, (messagesize % 16'(P)) != 16'd0};
   assign w_cnt_nxt = w_start ? 16'd1 : r_cnt + 16'd1;
   // Expected count of zero means the length check is disabled.
   assign w_len_err = w_take & (r_expbeats != 16'd0) &
                      (ilast ? (w_cnt_nxt != r_expbeats) : (w_cnt_nxt == r_expbeats));

   always_ff @(posedge ui_clk) begin
      if (sys_rst) begin
         r_state    <= S_IDLE;
         r_idx      <= '0;
         r_asm      <= '0;
         r_expbeats <= '0;
         r_cnt      <= '0;
         r_first    <= 1'b0;
         odata      <= '0;
         ovalid     <= 1'b0;
         ostart     <= 1'b0;
         olast      <= 1'b0;
         wordcount  <= '0;
         err        <= 1'b0;
      end else begin
         if (msvalid && (r_state == S_IDLE))
            r_expbeats <= w_exp;

         if (ovalid && oready) begin
            ovalid <= 1'b0;
            ostart <= 1'b0;
            olast  <= 1'b0;
         end

         if (w_take) begin
            r_cnt   <= w_cnt_nxt;
            r_state <= ilast ? S_IDLE : S_PACK;
            if (w_done) begin
               odata     <= w_word;
               ovalid    <= 1'b1;
               ostart    <= w_start | r_first;
               olast     <= ilast;
               wordcount <= w_start ? 16'd1 : wordcount + 16'd1;
               r_asm     <= '0;
               r_idx     <= '0;
               r_first   <= 1'b0;
            end else begin
               r_asm   <= w_word;
               r_idx   <= w_slot + IW'(1);
               r_first <= w_start | r_first;
               if (w_start)
                  wordcount <= '0;
            end
         end

         if (w_drop || w_restart || w_len_err)
            err <= 1'b1;
      end
   end
endmodule
